// File: rtl/vector_sequencer_if.sv
// ---------------------------------------------------------------------------
// vector_sequencer_if
//
// Bundles the request, register-file and status signals of the vector
// sequencer so that the sequencer and its environment connect through a
// single port. Clock and reset stay outside the bundle.
//
// Signal summary:
//   start            request pulse, sampled by the sequencer only while idle
//   vop[1:0]         operation: 00 ADD, 01 SUB, 10 AND, 11 ORR
//   vd/va/vb[3:0]    base register numbers for destination, source A, source B
//   vlen[2:0]        element count
//   rd1/rd2[31:0]    register-file read data (combinational from ra1/ra2)
//   ra1/ra2[3:0]     register-file read addresses
//   wa3[3:0]         register-file write address
//   wd3[31:0]        register-file write data
//   we3              register-file write enable
//   busy             high whenever the sequencer is not idle
//   stall            copy of busy, freezes the scalar pipeline
//   done             one-cycle completion pulse
//   err              qualified by done; high means the request was rejected
//
// Modports:
//   master  environment side (request source plus register file)
//   slave   sequencer side
// ---------------------------------------------------------------------------
interface vector_sequencer_if;
  logic        start;
  logic [1:0]  vop;
  logic [3:0]  vd;
  logic [3:0]  va;
  logic [3:0]  vb;
  logic [2:0]  vlen;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic [3:0]  wa3;
  logic [31:0] wd3;
  logic        we3;
  logic        busy;
  logic        stall;
  logic        done;
  logic        err;

  modport master (
    output start, vop, vd, va, vb, vlen, rd1, rd2,
    input  ra1, ra2, wa3, wd3, we3, busy, stall, done, err
  );

  modport slave (
    input  start, vop, vd, va, vb, vlen, rd1, rd2,
    output ra1, ra2, wa3, wd3, we3, busy, stall, done, err
  );
endinterface

// File: rtl/vector_sequencer.sv
// ---------------------------------------------------------------------------
// vector_sequencer
//
// Executes one element-wise vector operation (ADD/SUB/AND/ORR) over a range
// of scalar registers by time-multiplexing the scalar register file: each
// element takes one READ cycle (both operands read, result captured) and one
// WRITE cycle (result written back). Element i is written before element i+1
// is read, so overlapping source/destination ranges see sequential semantics.
// Requests whose length or register ranges are illegal are rejected in the
// CHECK state without touching the register file.
//
// Ports:
//   clk     sole clock, all state changes on its rising edge
//   reset   asynchronous, active-high reset
//   bus     vector_sequencer_if.slave (request, register-file port, status)
//
// Parameters:
//   MAXLEN  maximum vector length in elements
//   NREG    number of addressable registers (R0..R(NREG-1))
// ---------------------------------------------------------------------------
module vector_sequencer #(
  parameter int MAXLEN = 5,
  parameter int NREG   = 15
) (
  input  logic              clk,
  input  logic              reset,
  vector_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
  } state_t;

  // Highest register number a vector may touch.
  localparam logic [4:0] LAST_REG = 5'(NREG - 1);

  // Element-wise operation; ADD and SUB simply wrap modulo 2^32.
  function automatic logic [31:0] alu_op(input logic [1:0]  op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    case (op)
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b10:   r = a & b;
      2'b11:   r = a | b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // True when base+len-1 lands beyond the last register. Evaluated at 5 bits
  // so that a base near 15 cannot wrap back into range.
  function automatic logic range_over(input logic [3:0] base,
                                      input logic [2:0] len);
    logic [4:0] last_idx;
    last_idx = {1'b0, base} + {2'b00, len} - 5'd1;
    return (last_idx > LAST_REG);
  endfunction

  state_t      state_r;
  state_t      next_state_s;

  logic [1:0]  vop_r;
  logic [3:0]  vd_r;
  logic [3:0]  va_r;
  logic [3:0]  vb_r;
  logic [2:0]  vlen_r;

  logic [2:0]  i_r;
  logic [31:0] res_r;
  logic        bad_r;

  logic        bad_s;
  logic        last_elem_s;

  // Legality of the latched request; only consumed in CHECK.
  always_comb begin
    bad_s = (vlen_r == 3'd0)
          | ({29'd0, vlen_r} > 32'(MAXLEN))
          | range_over(vd_r, vlen_r)
          | range_over(va_r, vlen_r)
          | range_over(vb_r, vlen_r);
  end

  // The write of the final element is the one where i equals vlen-1.
  always_comb begin
    last_elem_s = (i_r == (vlen_r - 3'd1));
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          next_state_s = CHECK;
        end else begin
          next_state_s = IDLE;
        end
      end
      CHECK: begin
        if (bad_s) begin
          next_state_s = FIN;
        end else begin
          next_state_s = READ;
        end
      end
      READ: begin
        next_state_s = WRITE;
      end
      WRITE: begin
        if (last_elem_s) begin
          next_state_s = FIN;
        end else begin
          next_state_s = READ;
        end
      end
      FIN: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Request capture: fields are frozen at the accepting edge so later input
  // changes cannot disturb an operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vop_r  <= 2'd0;
      vd_r   <= 4'd0;
      va_r   <= 4'd0;
      vb_r   <= 4'd0;
      vlen_r <= 3'd0;
    end else if ((state_r == IDLE) && bus.start) begin
      vop_r  <= bus.vop;
      vd_r   <= bus.vd;
      va_r   <= bus.va;
      vb_r   <= bus.vb;
      vlen_r <= bus.vlen;
    end
  end

  // Element counter, result register and reject flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_r   <= 3'd0;
      res_r <= 32'd0;
      bad_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            i_r <= 3'd0;
          end
        end
        CHECK: begin
          bad_r <= bad_s;
        end
        READ: begin
          res_r <= alu_op(vop_r, bus.rd1, bus.rd2);
        end
        WRITE: begin
          i_r <= i_r + 3'd1;
        end
        default: begin
          i_r <= i_r;
        end
      endcase
    end
  end

  // Output decode from the registered state; every bus output sits at zero
  // except in the state that owns it, which keeps the register file quiet
  // during CHECK/FIN and while idle.
  always_comb begin
    bus.ra1   = 4'd0;
    bus.ra2   = 4'd0;
    bus.wa3   = 4'd0;
    bus.wd3   = 32'd0;
    bus.we3   = 1'b0;
    bus.done  = 1'b0;
    bus.err   = 1'b0;
    bus.busy  = (state_r != IDLE);
    bus.stall = (state_r != IDLE);
    case (state_r)
      READ: begin
        bus.ra1 = va_r + {1'b0, i_r};
        bus.ra2 = vb_r + {1'b0, i_r};
      end
      WRITE: begin
        bus.we3 = 1'b1;
        bus.wa3 = vd_r + {1'b0, i_r};
        bus.wd3 = res_r;
      end
      FIN: begin
        bus.done = 1'b1;
        bus.err  = bad_r;
      end
      default: begin
        bus.we3 = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vector_sequencer
//
// Self-checking bench for vector_sequencer. The bench owns a 16-entry
// register file attached to the sequencer's read/write ports, keeps a
// reference copy of the register contents, and pushes every expected write
// (address, data) onto a scoreboard queue when a request is issued. A monitor
// pops and compares on each observed write. Each scenario task checks
// latency, err, busy/stall and done counts inline.
// ---------------------------------------------------------------------------
module tb_vector_sequencer;

  logic clk;
  logic reset;

  vector_sequencer_if bus ();

  vector_sequencer #(.MAXLEN(5), .NREG(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] rf  [16];
  logic [31:0] mdl [16];
  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [31:0] pl_data;
  logic [35:0] exp_q [$];
  logic [35:0] mon_exp;

  int checks;
  int errors;
  int done_cnt;
  int wr_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.rd1 = rf[bus.ra1];
  assign bus.rd2 = rf[bus.ra2];

  // Register file: sequencer writes take priority over bench preloads.
  always @(posedge clk) begin
    if (bus.we3 === 1'b1) begin
      rf[bus.wa3] <= bus.wd3;
    end else if (pl_en) begin
      rf[pl_addr] <= pl_data;
    end
  end

  // Write scoreboard and done counter.
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.we3 === 1'b1) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write wa3=%0d wd3=%h (no write expected)", bus.wa3, bus.wd3);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.wa3, bus.wd3} !== mon_exp) begin
          errors++;
          $display("FAIL write_data got wa3=%0d wd3=%h expected wa3=%0d wd3=%h",
                   bus.wa3, bus.wd3, mon_exp[35:32], mon_exp[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  // Preload one register; called at a negedge while the sequencer is idle.
  task automatic load(input int a, input logic [31:0] v);
    pl_en   = 1'b1;
    pl_addr = 4'(a);
    pl_data = v;
    mdl[a]  = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request (called at a negedge) and check it to completion.
  task automatic run_req(input string name, input logic [1:0] op, input logic [3:0] d,
                         input logic [3:0] a, input logic [3:0] b, input logic [2:0] len,
                         input bit restart);
    bit          exp_bad;
    int          lat;
    int          cyc;
    int          d0;
    int          w0;
    logic [31:0] r;
    exp_bad = (len == 3'd0) || (int'(len) > 5) || (int'(d) + int'(len) - 1 > 14)
           || (int'(a) + int'(len) - 1 > 14) || (int'(b) + int'(len) - 1 > 14);
    lat = exp_bad ? 2 : 2 * int'(len) + 2;
    if (!exp_bad) begin
      for (int e = 0; e < int'(len); e++) begin
        r = ref_op(op, mdl[int'(a) + e], mdl[int'(b) + e]);
        mdl[int'(d) + e] = r;
        exp_q.push_back({4'(int'(d) + e), r});
      end
    end
    d0 = done_cnt;
    w0 = wr_cnt;
    bus.vop   = op;
    bus.vd    = d;
    bus.va    = a;
    bus.vb    = b;
    bus.vlen  = len;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.vop   = 2'($urandom);
    bus.vd    = 4'($urandom);
    bus.va    = 4'($urandom);
    bus.vb    = 4'($urandom);
    bus.vlen  = 3'($urandom);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 40) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.stall !== 1'b1) begin
        errors++;
        $display("FAIL %s busy cyc=%0d busy=%b stall=%b expected 1", name, cyc, bus.busy, bus.stall);
      end
      bus.start = (restart && cyc == 2) ? 1'b1 : 1'b0;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    checks++;
    if (cyc != lat) begin
      errors++;
      $display("FAIL %s latency got %0d expected %0d", name, cyc, lat);
    end
    checks++;
    if (bus.err !== exp_bad) begin
      errors++;
      $display("FAIL %s err got %b expected %b", name, bus.err, exp_bad);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL %s post_idle done=%b busy=%b expected 0", name, bus.done, bus.busy);
      end
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL %s done_count got %0d expected 1", name, done_cnt - d0);
    end
    checks++;
    if (wr_cnt - w0 != (exp_bad ? 0 : int'(len))) begin
      errors++;
      $display("FAIL %s write_count got %0d expected %0d", name, wr_cnt - w0,
               exp_bad ? 0 : int'(len));
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_writes got %0d pending expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.vop   = 2'd0;
    bus.vd    = 4'd0;
    bus.va    = 4'd0;
    bus.vb    = 4'd0;
    bus.vlen  = 3'd0;
    pl_en     = 1'b0;
    pl_addr   = 4'd0;
    pl_data   = 32'd0;
    #1;
    checks++;
    if ({bus.busy, bus.stall, bus.done, bus.err, bus.we3, bus.ra1, bus.ra2, bus.wa3, bus.wd3} !== 53'd0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b done=%b we3=%b ra1=%0d wa3=%0d wd3=%h expected all 0",
               bus.busy, bus.done, bus.we3, bus.ra1, bus.wa3, bus.wd3);
    end
    for (int k = 0; k < 16; k++) load(k, 32'(k * 7 + 100));
    load(0, 32'd1); load(1, 32'd2); load(2, 32'd3);
    load(3, 32'd10); load(4, 32'd20); load(5, 32'd30);
    checks++;
    if (bus.busy !== 1'b0 || bus.we3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold busy=%b we3=%b expected 0", bus.busy, bus.we3);
    end
    // Start is presented on the very first edge after reset release.
    reset = 1'b0;
    run_req("add_basic", 2'b00, 4'd6, 4'd0, 4'd3, 3'd3, 1'b0);
    checks++;
    if ({rf[6], rf[7], rf[8]} !== {32'd11, 32'd22, 32'd33}) begin
      errors++;
      $display("FAIL add_basic regs got %0d %0d %0d expected 11 22 33", rf[6], rf[7], rf[8]);
    end
  endtask

  task automatic test_sub;
    load(0, 32'd0);
    load(1, 32'd1);
    run_req("sub_wrap", 2'b01, 4'd2, 4'd0, 4'd1, 3'd1, 1'b0);
    checks++;
    if (rf[2] !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sub_wrap R2 got %h expected ffffffff", rf[2]);
    end
  endtask

  task automatic test_logic_ops;
    load(9, 32'hF0F0_1234);
    load(10, 32'hFFFF_FFFF);
    load(11, 32'h0F0F_00FF);
    load(12, 32'd2);
    run_req("and_op", 2'b10, 4'd0, 4'd9, 4'd11, 3'd2, 1'b0);
    run_req("orr_op", 2'b11, 4'd3, 4'd9, 4'd11, 3'd2, 1'b0);
    run_req("add_wrap", 2'b00, 4'd13, 4'd10, 4'd12, 3'd1, 1'b0);
    checks++;
    if ({rf[0], rf[3], rf[13]} !== {32'h0000_0034, 32'hFFFF_12FF, 32'd1}) begin
      errors++;
      $display("FAIL logic_regs got %h %h %h expected 00000034 ffff12ff 00000001", rf[0], rf[3], rf[13]);
    end
  endtask

  task automatic test_reject;
    run_req("rej_len0", 2'b00, 4'd0, 4'd0, 4'd0, 3'd0, 1'b0);
    run_req("rej_len6", 2'b00, 4'd0, 4'd0, 4'd0, 3'd6, 1'b0);
    run_req("rej_vd12", 2'b00, 4'd12, 4'd0, 4'd0, 3'd4, 1'b0);
    run_req("rej_va12", 2'b01, 4'd0, 4'd12, 4'd0, 3'd4, 1'b0);
    run_req("rej_vb15", 2'b11, 4'd0, 4'd0, 4'd15, 3'd1, 1'b0);
    run_req("edge_vd10", 2'b11, 4'd10, 4'd0, 4'd5, 3'd5, 1'b0);
    run_req("edge_va14", 2'b00, 4'd0, 4'd14, 4'd14, 3'd1, 1'b0);
  endtask

  task automatic test_overlap;
    load(0, 32'd1);
    load(5, 32'd1); load(6, 32'd1); load(7, 32'd1);
    run_req("overlap", 2'b00, 4'd1, 4'd0, 4'd5, 3'd3, 1'b0);
    checks++;
    if ({rf[1], rf[2], rf[3]} !== {32'd2, 32'd3, 32'd4}) begin
      errors++;
      $display("FAIL overlap regs got %0d %0d %0d expected 2 3 4", rf[1], rf[2], rf[3]);
    end
  endtask

  task automatic test_restart;
    run_req("restart", 2'b01, 4'd8, 4'd0, 4'd4, 3'd3, 1'b1);
  endtask

  task automatic test_reset_mid;
    int d0;
    int w0;
    for (int k = 0; k < 8; k++) load(k, 32'(k * 3 + 5));
    load(9, 32'hDEAD_BEEF);
    mdl[8] = mdl[0] + mdl[4];
    exp_q.push_back({4'd8, mdl[8]});
    d0 = done_cnt;
    w0 = wr_cnt;
    bus.vop = 2'b00; bus.vd = 4'd8; bus.va = 4'd0; bus.vb = 4'd4; bus.vlen = 3'd4;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ra1 !== 4'd1 || bus.ra2 !== 4'd5) begin
      errors++;
      $display("FAIL mid_read got ra1=%0d ra2=%0d expected 1 5", bus.ra1, bus.ra2);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.stall, bus.done, bus.err, bus.we3, bus.ra1, bus.ra2, bus.wa3, bus.wd3} !== 53'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs busy=%b ra1=%0d ra2=%0d we3=%b expected all 0",
               bus.busy, bus.ra1, bus.ra2, bus.we3);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (12) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_abort done=%b busy=%b expected 0", bus.done, bus.busy);
      end
    end
    checks++;
    if (wr_cnt - w0 != 1 || done_cnt - d0 != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_counts writes=%0d dones=%0d pending=%0d expected 1 0 0",
               wr_cnt - w0, done_cnt - d0, exp_q.size());
    end
    exp_q.delete();
    checks++;
    if (rf[8] !== mdl[8] || rf[9] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL mid_regs got R8=%h R9=%h expected %h deadbeef", rf[8], rf[9], mdl[8]);
    end
    run_req("after_reset", 2'b00, 4'd8, 4'd0, 4'd4, 3'd4, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [2:0] len;
    for (int k = 0; k < 15; k++) load(k, $urandom);
    for (int n = 0; n < 8; n++) begin
      len = 3'($urandom_range(1, 5));
      run_req("rand", 2'($urandom),
              4'($urandom_range(0, 15 - int'(len))),
              4'($urandom_range(0, 15 - int'(len))),
              4'($urandom_range(0, 15 - int'(len))), len, 1'b0);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    wr_cnt   = 0;
    test_reset();
    test_sub();
    test_logic_ops();
    test_reject();
    test_overlap();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_sequencer.md
VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 Parameters SHALL be:
- MAXLEN, default 5: maximum vector length in elements.
- NREG, default 15: number of addressable registers, R0..R14; address 15 is never accessed.
REQ-002 Reset SHALL be asynchronous and active-high; there SHALL be exactly one clock. Ports are listed below.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request pulse; sampled only in IDLE.
REQ-006 vop  in  2  operation: 00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-007 vd, va, vb  in  4 each  base register numbers for destination, source A and source B.
REQ-008 vlen  in  3  element count; legal range 1..MAXLEN.
REQ-009 rd1, rd2  in  32 each  register-file read data; combinational from ra1 and ra2.
REQ-010 ra1, ra2  out  4 each  register-file read addresses.
REQ-011 wa3  out  4  register-file write address.
REQ-012 wd3  out  32  register-file write data.
REQ-013 we3  out  1  register-file write enable.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 stall  out  1  equal to busy; freezes the scalar pipeline.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 err  out  1  valid only while done=1; high means the request was rejected.

Function
REQ-018 States SHALL be IDLE, CHECK, READ, WRITE and FIN, encoded in 3 bits.
REQ-019 IDLE with start=1 SHALL:
- latch vop, vd, va, vb and vlen into internal registers;
- clear element counter i to 0;
- go to CHECK.
IDLE with start=0 SHALL stay in IDLE.
REQ-020 CHECK SHALL set the internal bad flag when any of these holds:
- vlen==0;
- vlen>MAXLEN;
- vd+vlen-1>14, va+vlen-1>14 or vb+vlen-1>14, computed at 5-bit width so there is no wrap.
If bad, go to FIN; otherwise go to READ.
REQ-021 READ SHALL:
- drive ra1=va+i and ra2=vb+i;
- capture res = rd1 op rd2 into a 32-bit register at the clock edge;
- go to WRITE.
REQ-022 ADD and SUB SHALL wrap modulo 2^32; there are no flags and no saturation.
REQ-023 WRITE SHALL:
- drive we3=1, wa3=vd+i and wd3=res;
- increment i;
- go to FIN when i==vlen-1, otherwise go to READ.
REQ-024 FIN SHALL drive done=1 and err=bad for exactly one cycle, then go to IDLE.
REQ-025 Elements SHALL be processed in ascending order, with element i written before element i+1 is read.
- Overlapping vd/va/vb ranges therefore get sequential semantics.
- Element i+1 reads the new value written for element i.
REQ-026 Outside WRITE, we3 SHALL be 0; outside READ, ra1 and ra2 SHALL be 0.
REQ-027 Outside WRITE, wa3 and wd3 SHALL be 0.
REQ-028 start SHALL be ignored while busy=1 and SHALL NOT be queued.
REQ-029 Latency from the start edge to the done pulse SHALL be 2*vlen+2 cycles for a legal request and 2 cycles for a rejected one.
REQ-030 A rejected request SHALL issue no writes (we3 stays 0).
REQ-031 Changes on vop/vd/va/vb/vlen after the start edge SHALL have no effect until the next accepted start.

Reset
REQ-032 Asserting reset SHALL, asynchronously:
- set the state to IDLE;
- clear i, res, bad and all latched request fields;
- drive busy=stall=done=err=we3=0;
- drive ra1=ra2=wa3=0 and wd3=0.
REQ-033 Reset asserted mid-operation SHALL abort with no further writes.
- Writes already performed are not undone.
- After reset deasserts, no done pulse is produced for the aborted request.
REQ-034 For the first edge after reset deassertion, the block SHALL be in IDLE and SHALL accept start on that edge.

Verification
REQ-035 ADD, vd=6, va=0, vb=3, vlen=3, R0..R2=1,2,3, R3..R5=10,20,30 -> writes R6..R8=11,22,33 on the 3 WRITE cycles; done at cycle 8 with err=0; busy high cycles 1..8.
REQ-036 SUB, R0=0, R1=1, va=0, vb=1, vd=2, vlen=1 -> R2=0xFFFFFFFF; one we3 pulse; done at cycle 4.
REQ-037 vlen=0; vlen=6; and vd=12 with vlen=4 -> each gives done with err=1 at cycle 2 and we3 never asserted.
REQ-038 Overlap case, ADD, vd=1, va=0, vb=5, vlen=3, R0=1, R5..R7=1 -> R1=2, R2=3, R3=4, proving the sequential dependency.
REQ-039 start pulsed again during a running request -> ignored; exactly one done pulse.
REQ-040 reset asserted during the second READ of a vlen=4 request -> outputs 0 immediately; only element 0 written; no done pulse; a new request afterwards completes normally.
